// File: rtl/ps2_tx.sv
// ps2_tx -- host-to-device PS/2 transmitter.
//
// Sends one command byte to a PS/2 device (keyboard LED update, reset, ...).
// The sequence is: hold the clock line low to inhibit the device, post the
// start bit, release the clock, then place each data/parity bit on the data
// line after every device clock falling edge. Finally, release data for the
// stop bit and check the device's acknowledge on the 11th falling edge.
// While busy is high, the companion receiver should be disabled.
//
// Ports
//   mclk     in   system clock
//   reset    in   asynchronous active-low reset
//   ps2c_in  in   PS2C pin readback (asynchronous)
//   ps2d_in  in   PS2D pin readback (asynchronous)
//   ps2c_oe  out  1 = pull PS2C low, 0 = release (open collector)
//   ps2d_oe  out  1 = pull PS2D low, 0 = release (open collector)
//   wr_en    in   start strobe, only honoured while idle
//   din      in   command byte, captured when wr_en is accepted
//   busy     out  transfer in flight
//   tx_done  out  one-cycle pulse at the end of every transfer
//   tx_err   out  with tx_done: no acknowledge or timeout; held until next start
module ps2_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       mclk,
  input  logic       reset,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  input  logic       wr_en,
  input  logic [7:0] din,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, RTS, REQ, START, DATA, STOP, ACK, WAIT_BUS
  } state_t;

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic [1:0]            c_sync_reg;
  logic [1:0]            d_sync_reg;
  logic [FILTER_LEN-1:0] filt_reg;
  logic                  level_reg;
  logic                  fall;

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      c_sync_reg <= 2'b11;
      d_sync_reg <= 2'b11;
      filt_reg   <= '1;
      level_reg  <= 1'b1;
    end else begin
      c_sync_reg <= {c_sync_reg[0], ps2c_in};
      d_sync_reg <= {d_sync_reg[0], ps2d_in};
      filt_reg   <= {filt_reg[FILTER_LEN-2:0], c_sync_reg[1]};
      // Level only moves on a unanimous window; anything mixed holds it.
      if (filt_reg == '0)
        level_reg <= 1'b0;
      else if (filt_reg == '1)
        level_reg <= 1'b1;
    end
  end

  // High for exactly the one cycle before level_reg drops.
  assign fall = level_reg && (filt_reg == '0);

  // ---------------------------------------------------------------------------
  // Control FSM and datapath
  // ---------------------------------------------------------------------------
  state_t        state_reg, state_next;
  logic [8:0]    frame_reg, frame_next;
  logic [3:0]    bit_cnt_reg, bit_cnt_next;
  logic [IW-1:0] inh_cnt_reg, inh_cnt_next;
  logic [TW-1:0] tmo_cnt_reg, tmo_cnt_next;
  logic          c_oe_reg, c_oe_next;
  logic          d_oe_reg, d_oe_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;
  logic          err_reg, err_next;
  logic          tmo_hit;
  logic          abort;

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      frame_reg   <= '0;
      bit_cnt_reg <= '0;
      inh_cnt_reg <= '0;
      tmo_cnt_reg <= '0;
      c_oe_reg    <= 1'b0;
      d_oe_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      frame_reg   <= frame_next;
      bit_cnt_reg <= bit_cnt_next;
      inh_cnt_reg <= inh_cnt_next;
      tmo_cnt_reg <= tmo_cnt_next;
      c_oe_reg    <= c_oe_next;
      d_oe_reg    <= d_oe_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
    end
  end

  assign tmo_hit = (tmo_cnt_reg == TMO_LAST);

  always_comb begin
    state_next   = state_reg;
    frame_next   = frame_reg;
    bit_cnt_next = bit_cnt_reg;
    inh_cnt_next = inh_cnt_reg;
    tmo_cnt_next = tmo_cnt_reg;
    c_oe_next    = c_oe_reg;
    d_oe_next    = d_oe_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    err_next     = err_reg;
    abort        = 1'b0;

    case (state_reg)
      IDLE: begin
        c_oe_next = 1'b0;
        d_oe_next = 1'b0;
        busy_next = 1'b0;
        if (wr_en) begin
          frame_next   = {~^din, din};
          err_next     = 1'b0;
          inh_cnt_next = '0;
          c_oe_next    = 1'b1;
          busy_next    = 1'b1;
          state_next   = RTS;
        end
      end

      RTS: begin
        if (inh_cnt_reg == INH_LAST) begin
          d_oe_next  = 1'b1;
          state_next = REQ;
        end else begin
          inh_cnt_next = inh_cnt_reg + 1'b1;
        end
      end

      REQ: begin
        // Start bit stays on data while the clock is handed to the device.
        c_oe_next    = 1'b0;
        d_oe_next    = 1'b1;
        tmo_cnt_next = '0;
        state_next   = START;
      end

      START: begin
        if (fall) begin
          d_oe_next    = ~frame_reg[0];
          bit_cnt_next = '0;
          tmo_cnt_next = '0;
          state_next   = DATA;
        end else if (tmo_hit) begin
          abort = 1'b1;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + 1'b1;
        end
      end

      DATA: begin
        if (fall) begin
          tmo_cnt_next = '0;
          if (bit_cnt_reg == 4'd8) begin
            // Parity already on the line: release data for the stop bit.
            d_oe_next  = 1'b0;
            state_next = STOP;
          end else begin
            frame_next   = {1'b0, frame_reg[8:1]};
            d_oe_next    = ~frame_reg[1];
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end else if (tmo_hit) begin
          abort = 1'b1;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + 1'b1;
        end
      end

      STOP: begin
        if (fall) begin
          // Device acknowledges by holding data low across the 11th edge.
          tmo_cnt_next = '0;
          err_next     = d_sync_reg[1];
          state_next   = ACK;
        end else if (tmo_hit) begin
          abort = 1'b1;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + 1'b1;
        end
      end

      ACK: begin
        if (tmo_hit) begin
          abort = 1'b1;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + 1'b1;
          state_next   = WAIT_BUS;
        end
      end

      WAIT_BUS: begin
        if (level_reg && d_sync_reg[1]) begin
          done_next  = 1'b1;
          busy_next  = 1'b0;
          state_next = IDLE;
        end else if (tmo_hit) begin
          abort = 1'b1;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + 1'b1;
        end
      end

      default: begin
        c_oe_next  = 1'b0;
        d_oe_next  = 1'b0;
        busy_next  = 1'b0;
        state_next = IDLE;
      end
    endcase

    if (abort) begin
      c_oe_next  = 1'b0;
      d_oe_next  = 1'b0;
      busy_next  = 1'b0;
      done_next  = 1'b1;
      err_next   = 1'b1;
      state_next = IDLE;
    end
  end

  assign ps2c_oe = c_oe_reg;
  assign ps2d_oe = d_oe_reg;
  assign busy    = busy_reg;
  assign tx_done = done_reg;
  assign tx_err  = err_reg;

endmodule

// File: tb/tb_ps2_tx.sv
// tb_ps2_tx -- self-checking bench for ps2_tx with a behavioural PS/2 device.
// Expected bytes/acknowledge choices are queued when a command is issued and
// consumed by the device model, which compares what it clocks in.
module tb_ps2_tx;

  localparam int INH = 200;
  localparam int TMO = 3000;
  localparam int FLT = 8;
  localparam int HP  = 40;   // device clock half-period in mclk cycles

  typedef struct {
    logic [7:0] data;
    logic       ack;
  } exp_t;

  logic       mclk = 1'b0;
  logic       reset = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       glitch = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] din = 8'h00;
  logic       ps2c_in, ps2d_in;
  logic       ps2c_oe, ps2d_oe, busy, tx_done, tx_err;

  exp_t sb_q[$];
  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   txn     = 0;

  // Open-collector bus: either side may pull a line low.
  assign ps2c_in = dev_clk & ~ps2c_oe & ~glitch;
  assign ps2d_in = dev_data & ~ps2d_oe;

  always #5 mclk = ~mclk;

  ps2_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO),
    .FILTER_LEN    (FLT)
  ) dut (
    .mclk   (mclk),
    .reset  (reset),
    .ps2c_in(ps2c_in),
    .ps2d_in(ps2d_in),
    .ps2c_oe(ps2c_oe),
    .ps2d_oe(ps2d_oe),
    .wr_en  (wr_en),
    .din    (din),
    .busy   (busy),
    .tx_done(tx_done),
    .tx_err (tx_err)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue a command and follow the request-to-send phase up to clock release.
  task automatic send(input logic [7:0] b, input logic ack);
    int cnt;
    int req;
    exp_t e;
    @(negedge mclk);
    wr_en = 1'b1;
    din   = b;
    e.data = b;
    e.ack  = ack;
    sb_q.push_back(e);
    @(negedge mclk);
    wr_en = 1'b0;
    check_val("accept_busy", 32'(busy), 32'd1);
    check_val("accept_clk_low", 32'(ps2c_oe), 32'd1);
    cnt = 0;
    while (ps2c_oe && !ps2d_oe && cnt < 2 * INH) begin
      cnt++;
      @(negedge mclk);
    end
    check_val("inhibit_len", 32'(cnt), 32'(INH));
    req = 0;
    while (ps2c_oe && ps2d_oe && req < 10) begin
      req++;
      @(negedge mclk);
    end
    check_val("req_len", 32'(req), 32'd1);
    check_val("start_clk_rel", 32'(ps2c_oe), 32'd0);
    check_val("start_bit_drv", 32'(ps2d_oe), 32'd1);
  endtask

  // Device side of one frame. glitch_bit/reset_bit select the bit after whose
  // rising edge a disturbance is applied (0 = none).
  task automatic dev_xfer(input int glitch_bit, input logic mid_wr, input int reset_bit);
    exp_t        e;
    logic [10:0] got;
    int          n;
    if (sb_q.size() == 0) begin
      check_val("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb_q.pop_front();
    got = '0;
    got[0] = ps2d_in;
    for (int k = 1; k <= 10; k++) begin
      repeat (HP) @(negedge mclk);
      dev_clk = 1'b0;
      repeat (HP) @(negedge mclk);
      got[k] = ps2d_in;
      dev_clk = 1'b1;
      if (k == reset_bit) begin
        #3 reset = 1'b0;
        #1;
        check_val("rst_mid_clk_oe", 32'(ps2c_oe), 32'd0);
        check_val("rst_mid_dat_oe", 32'(ps2d_oe), 32'd0);
        check_val("rst_mid_busy", 32'(busy), 32'd0);
        $display("txn %0d: byte 0x%02h aborted by reset after bit %0d", txn, e.data, k);
        txn++;
        return;
      end
      if (k == glitch_bit) begin
        repeat (10) @(negedge mclk);
        glitch = 1'b1;
        repeat (3) @(negedge mclk);
        glitch = 1'b0;
      end
      if (mid_wr && k == 5) begin
        @(negedge mclk);
        wr_en = 1'b1;
        din   = 8'hFF;
        @(negedge mclk);
        wr_en = 1'b0;
      end
    end
    check_val("start_bit", 32'(got[0]), 32'd0);
    check_val("data_byte", 32'(got[8:1]), 32'(e.data));
    check_val("parity_bit", 32'(got[9]), 32'(($countones(e.data) % 2) == 0));
    check_val("stop_bit", 32'(got[10]), 32'd1);
    // 11th clock: acknowledge by holding data low across it.
    repeat (HP) @(negedge mclk);
    if (e.ack) dev_data = 1'b0;
    repeat (HP) @(negedge mclk);
    dev_clk = 1'b0;
    repeat (HP) @(negedge mclk);
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    n = 0;
    while (!tx_done && n < 2000) begin
      @(negedge mclk);
      n++;
    end
    check_val("done_seen", 32'(tx_done), 32'd1);
    check_val("tx_err", 32'(tx_err), 32'(!e.ack));
    check_val("busy_at_done", 32'(busy), 32'd0);
    check_val("end_clk_oe", 32'(ps2c_oe), 32'd0);
    check_val("end_dat_oe", 32'(ps2d_oe), 32'd0);
    $display("txn %0d: sent 0x%02h received 0x%02h par %0b stop %0b err %0b",
             txn, e.data, got[8:1], got[9], got[10], tx_err);
    txn++;
  endtask

  initial begin
    exp_t e;
    int   k;
    int   busy_seen;

    // Reset held with random strobes: everything must stay quiet.
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge mclk);
      wr_en = 1'($urandom_range(0, 1));
      din   = 8'($urandom);
    end
    check_val("rst_clk_oe", 32'(ps2c_oe), 32'd0);
    check_val("rst_dat_oe", 32'(ps2d_oe), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(tx_done), 32'd0);
    check_val("rst_err", 32'(tx_err), 32'd0);
    wr_en = 1'b0;
    @(negedge mclk);
    reset = 1'b1;
    repeat (100) @(negedge mclk);
    check_val("idle_busy", 32'(busy), 32'd0);
    check_val("idle_clk_oe", 32'(ps2c_oe), 32'd0);
    check_val("idle_dat_oe", 32'(ps2d_oe), 32'd0);

    // Set-LEDs command, acknowledged.
    send(8'hED, 1'b1);
    dev_xfer(0, 1'b0, 0);
    repeat (20) @(negedge mclk);

    // Zero byte, device never acknowledges.
    send(8'h00, 1'b0);
    dev_xfer(0, 1'b0, 0);
    repeat (20) @(negedge mclk);

    // Device silent after clock release.
    send(8'h5A, 1'b0);
    e = sb_q.pop_front();
    k = 0;
    while (!tx_done && k < TMO + 100) begin
      @(negedge mclk);
      k++;
    end
    check_val("timeout_cycles", 32'(k), 32'(TMO));
    check_val("timeout_err", 32'(tx_err), 32'(!e.ack));
    check_val("timeout_clk_oe", 32'(ps2c_oe), 32'd0);
    check_val("timeout_dat_oe", 32'(ps2d_oe), 32'd0);
    check_val("timeout_busy", 32'(busy), 32'd0);
    $display("txn %0d: sent 0x%02h timed out after %0d cycles err %0b", txn, e.data, k, tx_err);
    txn++;
    repeat (20) @(negedge mclk);

    // Clock glitch plus a stray write mid-frame.
    send(8'hA5, 1'b1);
    dev_xfer(4, 1'b1, 0);
    busy_seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge mclk);
      if (busy) busy_seen = 1;
    end
    check_val("no_queued_write", 32'(busy_seen), 32'd0);

    // Reset during the frame, then a clean transfer.
    send(8'h3C, 1'b1);
    dev_xfer(0, 1'b0, 4);
    repeat (10) @(negedge mclk);
    reset = 1'b1;
    repeat (20) @(negedge mclk);
    send(8'hFF, 1'b1);
    dev_xfer(0, 1'b0, 0);
    repeat (20) @(negedge mclk);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
